// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM encodings, default sizes and width helpers for fft_sched
package fft_pkg;

  localparam int LOG2_N_DEF   = 4;
  localparam int PIPE_LAT_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // sample-memory address width for a 2**log2n point transform
  function automatic int addr_w(input int log2n);
    return log2n;
  endfunction

  // twiddle ROM index width: N/2 distinct twiddles
  function automatic int tw_w(input int log2n);
    return log2n - 1;
  endfunction

endpackage

// File: rtl/fft_sched_if.sv
// rtl/fft_sched_if.sv - sequencer/datapath control bundle; scale_o exists only with FFT_SCHED_SCALE_EN
interface fft_sched_if #(parameter int LOG2_N = fft_pkg::LOG2_N_DEF);

  localparam int SW = $clog2(LOG2_N) + 1;
  localparam int AW = fft_pkg::addr_w(LOG2_N);
  localparam int TW = fft_pkg::tw_w(LOG2_N);

  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [SW-1:0] stage_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_a_o;
  logic [AW-1:0] rd_addr_b_o;
  logic [TW-1:0] tw_idx_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_a_o;
  logic [AW-1:0] wr_addr_b_o;
`ifdef FFT_SCHED_SCALE_EN
  logic          scale_o;
`endif

  modport master (
    input  start_i,
    output busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o,
           tw_idx_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
`ifdef FFT_SCHED_SCALE_EN
    , output scale_o
`endif
  );

  modport slave (
    output start_i,
    input  busy_o, done_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o,
           tw_idx_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
`ifdef FFT_SCHED_SCALE_EN
    , input scale_o
`endif
  );

endinterface

// File: rtl/fft_sched_dly.sv
// rtl/fft_sched_dly.sv - fixed-depth delay line for {valid, addr_a, addr_b}; only valids are reset
module fft_sched_dly #(
  parameter int DEPTH = 2,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic          o_valid,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b
);

  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_a [DEPTH];
  logic [AW-1:0]    r_b [DEPTH];

  // valid bits: cleared immediately on reset so an aborted transform never writes back
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // address bits: plain shift, qualified downstream by the valid
  always_ff @(posedge i_clk) begin
    r_a[0] <= i_addr_a;
    r_b[0] <= i_addr_b;
    for (int i = 1; i < DEPTH; i++) begin
      r_a[i] <= r_a[i-1];
      r_b[i] <= r_b[i-1];
    end
  end

  assign o_valid  = r_vld[DEPTH-1];
  assign o_addr_a = r_a[DEPTH-1];
  assign o_addr_b = r_b[DEPTH-1];

endmodule

// File: rtl/fft_sched.sv
// rtl/fft_sched.sv - radix-2 DIT FFT stage/butterfly sequencer with drained write-back; option FFT_SCHED_SCALE_EN
module fft_sched
  import fft_pkg::*;
#(
  parameter int LOG2_N   = LOG2_N_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input logic        clk_i,
  input logic        rst_i,
  fft_sched_if.master bus
);

  localparam int SW = $clog2(LOG2_N) + 1;
  localparam int KW = LOG2_N - 1;
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
  localparam logic [2:0]    D_LAST = 3'(PIPE_LAT - 1);

  state_t          r_state;
  logic [SW-1:0]   r_stage;
  logic [KW-1:0]   r_k;
  logic [2:0]      r_dcnt;

  logic              w_rd_en;
  logic [LOG2_N-1:0] w_k_ext;
  logic [LOG2_N-1:0] w_half;
  logic [LOG2_N-1:0] w_mask;
  logic [LOG2_N-1:0] w_pos;
  logic [LOG2_N-1:0] w_a;
  logic [LOG2_N-1:0] w_b;
  logic [KW-1:0]     w_tw;
  logic [LOG2_N-1:0] w_rd_a;
  logic [LOG2_N-1:0] w_rd_b;
  logic              w_wr_vld;
  logic [LOG2_N-1:0] w_wr_a;
  logic [LOG2_N-1:0] w_wr_b;

  // stage walk: RUN issues N/2 butterflies, DRAIN lets the last writes land before the next stage reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_state <= ST_RUN;
            r_stage <= '0;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          r_k <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_state <= ST_DRAIN;
            r_dcnt  <= '0;
          end
        end
        ST_DRAIN: begin
          if (r_dcnt == D_LAST) begin
            if (r_stage == S_LAST) begin
              r_state <= ST_DONE;
            end else begin
              r_stage <= r_stage + SW'(1);
              r_state <= ST_RUN;
            end
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // butterfly addressing: a = grp*2*half + pos, b = a + half, tw = pos << (LOG2_N-1-s)
  always_comb begin
    w_k_ext = {1'b0, r_k};
    w_half  = LOG2_N'(1) << r_stage;
    w_mask  = w_half - LOG2_N'(1);
    w_pos   = w_k_ext & w_mask;
    w_a     = ((w_k_ext & ~w_mask) << 1) | w_pos;
    w_b     = w_a | w_half;
    w_tw    = w_pos[KW-1:0] << (LOG2_N - 1 - int'(r_stage));
  end

  assign w_rd_en = (r_state == ST_RUN);
  assign w_rd_a  = w_rd_en ? w_a : '0;
  assign w_rd_b  = w_rd_en ? w_b : '0;

  fft_sched_dly #(.DEPTH(PIPE_LAT), .AW(LOG2_N)) u_dly (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_valid  (w_rd_en),
    .i_addr_a (w_rd_a),
    .i_addr_b (w_rd_b),
    .o_valid  (w_wr_vld),
    .o_addr_a (w_wr_a),
    .o_addr_b (w_wr_b)
  );

  assign bus.busy_o      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bus.done_o      = (r_state == ST_DONE);
  assign bus.stage_o     = r_stage;
  assign bus.rd_en_o     = w_rd_en;
  assign bus.rd_addr_a_o = w_rd_a;
  assign bus.rd_addr_b_o = w_rd_b;
  assign bus.tw_idx_o    = w_rd_en ? w_tw : '0;
  assign bus.wr_en_o     = w_wr_vld;
  assign bus.wr_addr_a_o = w_wr_vld ? w_wr_a : '0;
  assign bus.wr_addr_b_o = w_wr_vld ? w_wr_b : '0;
`ifdef FFT_SCHED_SCALE_EN
  assign bus.scale_o     = w_wr_vld;
`endif

endmodule

// File: tb/tb_fft_sched.sv
// tb/tb_fft_sched.sv - scoreboard bench for fft_sched (LOG2_N=4, PIPE_LAT=2)
module tb_fft_sched;

  localparam int LOG2_N = 4;
  localparam int PL     = 2;
  localparam int NB     = 8;
  localparam int SLEN   = NB + PL;

  typedef struct {
    int cyc;
    int s;
    int a;
    int b;
    int tw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   posedges = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   busy_cnt = 0;
  exp_t rdq[$];
  exp_t wrq[$];
  int   dq[$];
  exp_t m_e;
  int   m_d;

  fft_sched_if #(.LOG2_N(LOG2_N)) bus ();

  fft_sched #(.LOG2_N(LOG2_N), .PIPE_LAT(PL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) posedges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // expected butterflies for one transform whose first issue period has posedges == e0
  task automatic push_xfer(input int e0);
    exp_t e;
    int half;
    for (int s = 0; s < LOG2_N; s++) begin
      half = 1 << s;
      for (int grp = 0; grp < NB / half; grp++) begin
        for (int pos = 0; pos < half; pos++) begin
          e.s   = s;
          e.a   = grp * 2 * half + pos;
          e.b   = e.a + half;
          e.tw  = pos * ((NB) / half);
          e.cyc = e0 + s * SLEN + grp * half + pos;
          rdq.push_back(e);
          e.cyc = e.cyc + PL;
          wrq.push_back(e);
        end
      end
    end
    dq.push_back(e0 + LOG2_N * SLEN);
  endtask

  task automatic do_start(input bit hold, output int e0);
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    e0 = posedges;
    if (!hold) bus.start_i = 1'b0;
  endtask

  task automatic wait_period(input int target);
    int guard;
    guard = 0;
    while (posedges != target && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("wait_period_reached", (posedges == target), 1);
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (n_done < target && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    chk("done_seen_in_time", (n_done >= target), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  bus.busy_o, 0);
    chk({tag, "_done"},  bus.done_o, 0);
    chk({tag, "_rd_en"}, bus.rd_en_o, 0);
    chk({tag, "_rd_a"},  bus.rd_addr_a_o, 0);
    chk({tag, "_rd_b"},  bus.rd_addr_b_o, 0);
    chk({tag, "_tw"},    bus.tw_idx_o, 0);
    chk({tag, "_wr_en"}, bus.wr_en_o, 0);
    chk({tag, "_wr_a"},  bus.wr_addr_a_o, 0);
    chk({tag, "_wr_b"},  bus.wr_addr_b_o, 0);
`ifdef FFT_SCHED_SCALE_EN
    chk({tag, "_scale"}, bus.scale_o, 0);
`endif
  endtask

  // monitor: compares every issued read, write-back and done pulse against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy_o) busy_cnt++;
      if (bus.rd_en_o) begin
        chk("rd_expected", (rdq.size() != 0), 1);
        if (rdq.size() != 0) begin
          m_e = rdq.pop_front();
          chk("rd_cycle", posedges, m_e.cyc);
          chk("rd_stage", bus.stage_o, m_e.s);
          chk("rd_addr_a", bus.rd_addr_a_o, m_e.a);
          chk("rd_addr_b", bus.rd_addr_b_o, m_e.b);
          chk("tw_idx", bus.tw_idx_o, m_e.tw);
        end
      end
      if (bus.wr_en_o) begin
        chk("wr_expected", (wrq.size() != 0), 1);
        if (wrq.size() != 0) begin
          m_e = wrq.pop_front();
          chk("wr_cycle", posedges, m_e.cyc);
          chk("wr_addr_a", bus.wr_addr_a_o, m_e.a);
          chk("wr_addr_b", bus.wr_addr_b_o, m_e.b);
        end
      end
`ifdef FFT_SCHED_SCALE_EN
      if (bus.wr_en_o || bus.scale_o) chk("scale_eq_wr_en", bus.scale_o, bus.wr_en_o);
`endif
      if (bus.done_o) begin
        n_done++;
        chk("done_expected", (dq.size() != 0), 1);
        if (dq.size() != 0) begin
          m_d = dq.pop_front();
          chk("done_cycle", posedges, m_d);
        end
        chk("busy_len", busy_cnt, LOG2_N * SLEN);
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int e0;
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_stage", bus.stage_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // transform A with a start pulse mid-run that must be ignored
    do_start(1'b0, e0);
    push_xfer(e0);
    wait_period(e0 + 19);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_done(1);
    repeat (6) @(posedge clk);
    chk("idle_after_A", bus.busy_o, 0);

    // transforms B and C: start held through DONE re-arms from IDLE
    do_start(1'b1, e0);
    push_xfer(e0);
    push_xfer(e0 + LOG2_N * SLEN + 2);
    wait_period(e0 + 45);
    bus.start_i = 1'b0;
    wait_done(3);
    repeat (6) @(posedge clk);

    // abort in cycle 15 of a transform
    do_start(1'b0, e0);
    push_xfer(e0);
    wait_period(e0 + 14);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    rdq.delete();
    wrq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_all_zero("post_abort");

    // transform D reproduces the full sequence after the abort
    do_start(1'b0, e0);
    push_xfer(e0);
    wait_done(4);
    repeat (6) @(posedge clk);

    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    chk("done_count", n_done, 4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_sched.md
# fft_sched

Control sequencer for a radix-2 decimation-in-time FFT built around one shared combinational butterfly and a dual-port in-place sample memory. On a start request it walks all LOG2_N stages, issuing one butterfly per cycle. Each butterfly gets the A/B read addresses and the twiddle ROM index. The block also produces the matching write-back addresses, delayed by the datapath latency, and drains the pipeline between stages so that no stage reads stale data.

## Interface
- LOG2_N, 4: log2 of FFT length; N = 2**LOG2_N, N/2 butterflies per stage
- PIPE_LAT, 2: cycles from read issue to write-back; 1 memory read cycle plus 1 result register; legal range 1..4
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; asynchronous and active-high
- start_i  in  1  start request; sampled only in IDLE
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse; transform complete
- stage_o  out  $clog2(LOG2_N)+1  current stage index s
- rd_en_o  out  1  butterfly issue / memory read enable
- rd_addr_a_o, rd_addr_b_o  out  LOG2_N  read addresses, A and B operands
- tw_idx_o  out  LOG2_N-1  twiddle ROM index, valid with rd_en_o
- wr_en_o  out  1  write-back enable
- wr_addr_a_o, wr_addr_b_o  out  LOG2_N  write addresses for butterfly a_o and b_o

## Operation
- Memory holds input in bit-reversed order; the result is in natural order. In-place: write address equals the read address issued PIPE_LAT cycles earlier.
- Per stage s (0..LOG2_N-1), counter k runs 0..N/2-1:
  - half = 2**s, grp = k>>s, pos = k & (half-1)
  - a = grp*2*half + pos; b = a + half
  - tw = pos << (LOG2_N-1-s)
- States:
  - IDLE: start_i=1 moves to RUN, with s=0 and k=0.
  - RUN: rd_en_o=1 and k increments each cycle. At k=N/2-1 go to DRAIN and clear the drain counter.
  - DRAIN: runs PIPE_LAT cycles with rd_en_o=0. After the last cycle: if s<LOG2_N-1, increment s and go to RUN with k=0; otherwise go to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- start_i in any state other than IDLE is ignored; there is no restart or abort.
- Write pipe: shift register of depth PIPE_LAT carrying {rd_en, addr_a, addr_b}; the output drives wr_en_o and wr_addr_*.
- Arithmetic: all address math is unsigned, LOG2_N bits, with no wrap. The maximum b is N-1.

## Timing
- Reset values: state IDLE, all outputs 0, write pipe valids cleared. Reset mid-transform aborts at once, and no write-back is issued after reset deasserts.
- Start is sampled at edge E0. rd_en_o is high in the N/2 cycles after E0.
- A butterfly issued in cycle t has wr_en_o in cycle t+PIPE_LAT.
- The last write of stage s precedes the first read of stage s+1 by 1 cycle. The memory must return written data on the following read.
- Busy length = LOG2_N*(N/2+PIPE_LAT) cycles, followed by the done_o cycle. Defaults: 40 busy cycles, done_o in cycle 41 after E0.
- start_i held high through DONE starts a new transform on the cycle after DONE, in IDLE.

## Configuration
- FFT_SCHED_SCALE_EN defined:
  - Adds output scale_o (1 bit), registered alongside wr_en_o and equal to it.
  - The datapath arithmetic-shifts butterfly outputs right by 1 when scale_o=1, which gives 1/N total scaling and prevents growth.
- FFT_SCHED_SCALE_EN undefined: the port is absent and the datapath keeps full growth of LOG2_N bits.

## Structure
- Shared package fft_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - default LOG2_N and PIPE_LAT
  - address-width and twiddle-width helper functions
- One sub-module, fft_sched_dly: a parameterised-depth delay line for {valid, addr_a, addr_b}. Its valids are reset asynchronously; its address bits are not reset.

## Test plan
- Stage 0, LOG2_N=4: after start, issue pairs (0,1),(2,3),…,(14,15) with tw=0 on all.
- Stage 1: (0,2,tw0),(1,3,tw4),(4,6,tw0),(5,7,tw4),…
- Stage 3: (k, k+8, tw=k) for k=0..7.
- Write-back: each wr_addr pair equals the rd_addr pair exactly 2 cycles earlier. No rd_en_o in the 2 DRAIN cycles. done_o pulses once, 41 cycles after E0.
- Abort: assert rst_i in cycle 15 of the transform → all outputs 0 immediately, no wr_en_o afterwards. A new start then reproduces the stage-0 sequence.
- start_i pulsed while busy is ignored. With FFT_SCHED_SCALE_EN, scale_o matches wr_en_o on all 32 writes.
